queue_mem_ctrl: RTL and testbench

//  Sequencer for the 4-write/1-read dual-port queue memory: treats it as a circular FIFO.

---
 rtl/qmc_pkg.sv | 5 +
 rtl/qmc_occupancy.sv | 24 ++
 rtl/queue_mem_ctrl.sv | 97 +++++++++
 tb/tb_queue_mem_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/qmc_pkg.sv
// qmc_pkg: shared state type and group size for the queue memory controller
package qmc_pkg;
  typedef enum logic {QMC_CLEAR, QMC_RUN} qmc_state_e;
  localparam int GROUP_WORDS = 4;
endpackage

// File: rtl/qmc_occupancy.sv
// qmc_occupancy: word count register with full/empty decode
module qmc_occupancy
  import qmc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_acc,
  input  logic            rd_gnt,
  input  logic            flush,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty
);
  localparam int CW = ADDR_W + 1;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= flush ? '0 : count + (wr_acc ? CW'(GROUP_WORDS) : '0) - CW'(rd_gnt);
  // full means a whole group no longer fits
  assign full  = count > CW'(DEPTH - GROUP_WORDS);
  assign empty = count == '0;
endmodule

// File: rtl/queue_mem_ctrl.sv
// queue_mem_ctrl: circular FIFO sequencer for a 4-write/1-read queue memory.
// Define QMC_CLEAR_EN to zero the memory after reset and flush before accepting traffic.
module queue_mem_ctrl
  import qmc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic                flush,
  input  logic                rd_req,
  output logic                rd_gnt,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic                mem_wr_ena,
  output logic                mem_rd_ena,
  output logic [ADDR_W-1:0]   mem_addra0,
  output logic [ADDR_W-1:0]   mem_addra1,
  output logic [ADDR_W-1:0]   mem_addra2,
  output logic [ADDR_W-1:0]   mem_addra3,
  output logic [DATA_W-1:0]   mem_dina0,
  output logic [DATA_W-1:0]   mem_dina1,
  output logic [DATA_W-1:0]   mem_dina2,
  output logic [DATA_W-1:0]   mem_dina3,
  output logic                mem_wr_enb,
  output logic                mem_rd_enb,
  output logic [ADDR_W-1:0]   mem_addr_rdb,
  input  logic [DATA_W-1:0]   mem_doutb,
  input  logic                mem_out_valid
);
`ifdef QMC_CLEAR_EN
  localparam qmc_state_e RST_STATE = QMC_CLEAR;
`else
  localparam qmc_state_e RST_STATE = QMC_RUN;
`endif
  qmc_state_e state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, base;
  logic [ADDR_W-3:0] clr_idx;
  logic run, clr_wr, wr_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= RST_STATE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= (flush || state != QMC_CLEAR) ? '0 : clr_idx + 1'b1;
    end
  always_comb begin
`ifdef QMC_CLEAR_EN
    state_nxt = flush ? QMC_CLEAR : (state == QMC_CLEAR && &clr_idx) ? QMC_RUN : state;
`else
    state_nxt = QMC_RUN;
`endif
  end
  assign run      = state == QMC_RUN && !rst;
  assign clr_wr   = state == QMC_CLEAR && !rst;
  assign in_ready = run & !full & !flush;
  assign wr_acc   = in_valid & in_ready;
  assign rd_gnt   = run & rd_req & !empty & !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(GROUP_WORDS);
      if (rd_gnt) rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  // CLEAR and RUN writes are exclusive since in_ready is low during CLEAR
  assign base       = clr_wr ? {clr_idx, 2'b00} : wr_ptr;
  assign mem_wr_ena = wr_acc | clr_wr;
  assign mem_rd_ena = 1'b0;
  assign mem_addra0 = base;
  assign mem_addra1 = base + ADDR_W'(1);
  assign mem_addra2 = base + ADDR_W'(2);
  assign mem_addra3 = base + ADDR_W'(3);
  assign mem_dina0  = clr_wr ? '0 : in_data[0*DATA_W +: DATA_W];
  assign mem_dina1  = clr_wr ? '0 : in_data[1*DATA_W +: DATA_W];
  assign mem_dina2  = clr_wr ? '0 : in_data[2*DATA_W +: DATA_W];
  assign mem_dina3  = clr_wr ? '0 : in_data[3*DATA_W +: DATA_W];
  assign mem_wr_enb   = 1'b0;
  assign mem_rd_enb   = rd_gnt;
  assign mem_addr_rdb = rd_ptr;
  assign out_data     = mem_doutb;
  assign out_valid    = mem_out_valid;
  qmc_occupancy #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_occ (
    .clk(clk), .rst(rst), .wr_acc(wr_acc), .rd_gnt(rd_gnt), .flush(flush),
    .count(count), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_queue_mem_ctrl.sv
// tb_queue_mem_ctrl: directed and randomized checks against a queue-level reference model
module tb_queue_mem_ctrl;
  localparam int AW = 5, DW = 32, DEPTH = 32;
`ifdef QMC_CLEAR_EN
  localparam int CLR = DEPTH / 4;
`else
  localparam int CLR = 0;
`endif
  logic clk = 0, rst, in_valid, in_ready, flush, rd_req, rd_gnt, out_valid, full, empty;
  logic [4*DW-1:0] in_data;
  logic [DW-1:0] out_data, mem_doutb;
  logic [AW:0] count;
  logic mem_wr_ena, mem_rd_ena, mem_wr_enb, mem_rd_enb, mem_out_valid;
  logic [AW-1:0] addra [4];
  logic [DW-1:0] dina [4];
  logic [AW-1:0] mem_addr_rdb;
  logic [DW-1:0] mem [DEPTH];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  queue_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .rd_req(rd_req), .rd_gnt(rd_gnt), .out_data(out_data), .out_valid(out_valid),
    .count(count), .full(full), .empty(empty), .mem_wr_ena(mem_wr_ena), .mem_rd_ena(mem_rd_ena),
    .mem_addra0(addra[0]), .mem_addra1(addra[1]), .mem_addra2(addra[2]), .mem_addra3(addra[3]),
    .mem_dina0(dina[0]), .mem_dina1(dina[1]), .mem_dina2(dina[2]), .mem_dina3(dina[3]),
    .mem_wr_enb(mem_wr_enb), .mem_rd_enb(mem_rd_enb), .mem_addr_rdb(mem_addr_rdb),
    .mem_doutb(mem_doutb), .mem_out_valid(mem_out_valid)
  );

  // dual-port memory the controller sequences: 4 writes on A, 1-cycle registered read on B
  always @(posedge clk or posedge rst)
    if (rst) mem_out_valid <= 1'b0;
    else begin
      mem_out_valid <= mem_rd_enb;
      if (mem_rd_enb) mem_doutb <= mem[mem_addr_rdb];
      if (mem_wr_ena) for (int k = 0; k < 4; k++) mem[addra[k]] <= dina[k];
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: queue of words plus word counters since last reset/flush
  logic [DW-1:0] q[$];
  int wcnt = 0, rcnt = 0, clear_left = CLR;
  logic pend_valid = 0, m_acc = 0, m_gnt = 0;
  logic [DW-1:0] pend_data = 0;

  always @(negedge clk) begin
    logic e_rdy, e_wr, run;
    int e_cnt, b;
    run = 0; e_rdy = 0; e_wr = 0; e_cnt = 0; b = 0;
    if (rst) begin
      m_acc = 0; m_gnt = 0;
    end else begin
      run   = clear_left == 0;
      e_rdy = run && q.size() <= DEPTH - 4 && !flush;
      m_acc = in_valid && e_rdy;
      m_gnt = run && rd_req && q.size() > 0 && !flush;
      e_cnt = q.size();
      e_wr  = m_acc || !run;
    end
    chk("in_ready", in_ready, e_rdy);
    chk("rd_gnt", rd_gnt, m_gnt);
    chk("mem_rd_enb", mem_rd_enb, m_gnt);
    chk("count", count, e_cnt);
    chk("full", full, e_cnt > DEPTH - 4);
    chk("empty", empty, e_cnt == 0);
    chk("mem_wr_ena", mem_wr_ena, e_wr);
    chk("mem_rd_ena", mem_rd_ena, 0);
    chk("mem_wr_enb", mem_wr_enb, 0);
    chk("out_valid", out_valid, !rst && pend_valid);
    if (!rst && pend_valid) chk("out_data", out_data, pend_data);
    if (m_gnt) chk("mem_addr_rdb", mem_addr_rdb, rcnt);
    if (e_wr) begin
      b = run ? wcnt : 4 * (CLR - clear_left);
      for (int k = 0; k < 4; k++) begin
        chk("mem_addra", addra[k], (b + k) % DEPTH);
        chk("mem_dina", dina[k], run ? in_data[k*DW +: DW] : 0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); wcnt = 0; rcnt = 0; pend_valid = 0; clear_left = CLR;
    end else begin
      pend_valid = m_gnt;
      if (m_gnt) begin
        pend_data = q.pop_front();
        rcnt = (rcnt + 1) % DEPTH;
      end
      if (m_acc) begin
        for (int k = 0; k < 4; k++) q.push_back(in_data[k*DW +: DW]);
        wcnt = (wcnt + 4) % DEPTH;
      end
      if (flush) begin
        q.delete(); wcnt = 0; rcnt = 0; clear_left = CLR;
      end else if (clear_left > 0) clear_left--;
    end
  end

  logic collect = 0;
  logic [DW-1:0] got[$];
  always @(negedge clk) if (collect && out_valid) got.push_back(out_data);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw, pr;
    rst = 1; in_valid = 0; in_data = '0; flush = 0; rd_req = 0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 0);
    cyc(); rst = 0;
    repeat (CLR) cyc();
    for (int g = 0; g < 4; g++) begin
      in_valid = 1;
      for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = 32'h10 + 4 * g + k;
      cyc();
    end
    in_valid = 0;
    @(negedge clk);
    chk("lit_count16", count, 16);
    collect = 1;
    cyc(); rd_req = 1;
    repeat (16) cyc();
    rd_req = 0;
    repeat (2) cyc();
    collect = 0;
    chk("lit_nreads", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("lit_rd_order", got[i], 32'h10 + i);
    for (int g = 0; g < 11; g++) begin
      in_valid = 1;
      for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = 32'h100 + 4 * g + k;
      cyc();
    end
    @(negedge clk);
    chk("lit_count32", count, 32);
    chk("lit_full", full, 1);
    chk("lit_held", in_ready, 0);
    in_valid = 0;
    cyc(); rd_req = 1;
    repeat (4) cyc();
    rd_req = 0;
    @(negedge clk);
    chk("lit_count28", count, 28);
    chk("lit_ready28", in_ready, 1);
    chk("lit_notfull28", full, 0);
    cyc(); flush = 1;
    cyc(); flush = 0;
    @(negedge clk);
    chk("lit_flush_count", count, 0);
    chk("lit_flush_empty", empty, 1);
    pw = 50; pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      in_valid = $urandom_range(0, 99) < pw;
      rd_req   = $urandom_range(0, 99) < pr;
      flush    = $urandom_range(0, 79) == 0;
      rst      = $urandom_range(0, 499) == 0;
      for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = $urandom;
      cyc();
    end
    rst = 0; flush = 0; in_valid = 0; rd_req = 0;
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
